// File: rtl/id_exe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_stage_reg_pkg
// Purpose  : Shared widths, control bundle and forwarding select codes for
//            the ID/EX pipeline register and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
package id_exe_stage_reg_pkg;

  localparam int EXE_CMD_LEN               = 4;
  localparam int SHIFT_OPERAND_LEN         = 12;
  localparam int SIGNED_IMM_LEN            = 24;
  localparam int STATUS_LEN                = 4;
  localparam int REGISTER_FILE_ADDRESS_LEN = 4;

  // Operand-mux select codes used by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  // Control bits that must all be dropped together when a bubble is inserted.
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

endpackage : id_exe_stage_reg_pkg
`default_nettype wire

// File: rtl/id_exe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping.
//            Cleared only by the asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count events, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_stage_reg
// Purpose  : Decode -> execute pipeline register with memory-stall hold,
//            flush/hazard bubble insertion and saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_stall,
  input  logic                         flush,
  input  logic                         hazard,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            val_rn_in,
  input  logic [DATA_W-1:0]            val_rm_in,
  input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in,
  input  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_in,
  input  logic                         imm_in,
  input  logic [EXE_CMD_LEN-1:0]       exe_cmd_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic                         wb_en_in,
  input  logic                         b_in,
  input  logic                         s_in,
  input  logic [REG_ADDR_W-1:0]        dest_in,
  input  logic [REG_ADDR_W-1:0]        src1_in,
  input  logic [REG_ADDR_W-1:0]        src2_in,
  input  logic [STATUS_LEN-1:0]        status_in,
  output logic [DATA_W-1:0]            pc_out,
  output logic [DATA_W-1:0]            val_rn_out,
  output logic [DATA_W-1:0]            val_rm_out,
  output logic [SHIFT_OPERAND_LEN-1:0] shift_operand_out,
  output logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_out,
  output logic                         imm_out,
  output logic [EXE_CMD_LEN-1:0]       exe_cmd_out,
  output logic                         mem_r_en_out,
  output logic                         mem_w_en_out,
  output logic                         wb_en_out,
  output logic                         b_out,
  output logic                         s_out,
  output logic [REG_ADDR_W-1:0]        dest_out,
  output logic [REG_ADDR_W-1:0]        src1_out,
  output logic [REG_ADDR_W-1:0]        src2_out,
  output logic [STATUS_LEN-1:0]        status_out,
  output logic                         valid_out,
  output logic [CNT_W-1:0]             bubble_count,
  output logic [CNT_W-1:0]             stall_count
);

  // A stall freezes everything, so a flush/hazard seen during a stall is
  // not acted upon; the frozen neighbours will present it again.
  logic  do_bubble;
  logic  do_load;
  ctrl_t ctrl_in;
  ctrl_t ctrl_q;

  // Decode the single action taken at the next edge, by priority.
  always_comb begin
    do_bubble = 1'b0;
    do_load   = 1'b0;
    ctrl_in   = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                  b: b_in, s: s_in};
    if (!mem_stall) begin
      do_bubble = flush | hazard;
      do_load   = ~(flush | hazard);
    end
  end

  // Field register: load on a normal cycle, zero every field on a bubble so
  // no forwarding match or writeback can come from it, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      imm_out           <= 1'b0;
      exe_cmd_out       <= '0;
      ctrl_q            <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      status_out        <= '0;
      valid_out         <= 1'b0;
    end else if (do_bubble) begin
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      imm_out           <= 1'b0;
      exe_cmd_out       <= '0;
      ctrl_q            <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      status_out        <= '0;
      valid_out         <= 1'b0;
    end else if (do_load) begin
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      imm_out           <= imm_in;
      exe_cmd_out       <= exe_cmd_in;
      ctrl_q            <= ctrl_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      status_out        <= status_in;
      valid_out         <= 1'b1;
    end
  end

  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_bubble),
    .count (bubble_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .count (stall_count)
  );

endmodule : id_exe_stage_reg
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_exe_stage_reg
// Purpose  : Directed + randomized bench for id_exe_stage_reg, checked
//            against a field-level reference model. A second instance with
//            4-bit counters exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] imm24;
    logic        imm;
    logic [3:0]  cmd;
    logic        mr, mw, wb, b, s;
    logic [3:0]  dest, src1, src2, status;
    logic        valid;
  } fields_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_stall, flush, hazard;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in, status_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, valid_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [15:0] bubble_count, stall_count;

  logic [31:0] sm_pc, sm_rn, sm_rm;
  logic [11:0] sm_sh;
  logic [23:0] sm_imm24;
  logic sm_imm, sm_mr, sm_mw, sm_wb, sm_b, sm_s, sm_valid;
  logic [3:0] sm_cmd, sm_dest, sm_src1, sm_src2, sm_status;
  logic [3:0] sm_bubble_count, sm_stall_count;

  int checks = 0;
  int passed = 0;

  // Reference model state
  fields_t exp_f;
  int      n_bubbles, n_stalls;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .hazard(hazard),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .imm_out(imm_out), .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .status_out(status_out), .valid_out(valid_out),
    .bubble_count(bubble_count), .stall_count(stall_count)
  );

  id_exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .hazard(hazard),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .pc_out(sm_pc), .val_rn_out(sm_rn), .val_rm_out(sm_rm),
    .shift_operand_out(sm_sh), .signed_imm_24_out(sm_imm24),
    .imm_out(sm_imm), .exe_cmd_out(sm_cmd), .mem_r_en_out(sm_mr),
    .mem_w_en_out(sm_mw), .wb_en_out(sm_wb), .b_out(sm_b), .s_out(sm_s),
    .dest_out(sm_dest), .src1_out(sm_src1), .src2_out(sm_src2),
    .status_out(sm_status), .valid_out(sm_valid),
    .bubble_count(sm_bubble_count), .stall_count(sm_stall_count)
  );

  function automatic fields_t inputs_now();
    fields_t f;
    f = '{pc: pc_in, rn: val_rn_in, rm: val_rm_in, sh: shift_operand_in,
          imm24: signed_imm_24_in, imm: imm_in, cmd: exe_cmd_in,
          mr: mem_r_en_in, mw: mem_w_en_in, wb: wb_en_in, b: b_in, s: s_in,
          dest: dest_in, src1: src1_in, src2: src2_in, status: status_in,
          valid: 1'b1};
    return f;
  endfunction

  function automatic fields_t outputs_now();
    fields_t f;
    f = '{pc: pc_out, rn: val_rn_out, rm: val_rm_out, sh: shift_operand_out,
          imm24: signed_imm_24_out, imm: imm_out, cmd: exe_cmd_out,
          mr: mem_r_en_out, mw: mem_w_en_out, wb: wb_en_out, b: b_out, s: s_out,
          dest: dest_out, src1: src1_out, src2: src2_out, status: status_out,
          valid: valid_out};
    return f;
  endfunction

  function automatic fields_t small_outputs_now();
    fields_t f;
    f = '{pc: sm_pc, rn: sm_rn, rm: sm_rm, sh: sm_sh, imm24: sm_imm24,
          imm: sm_imm, cmd: sm_cmd, mr: sm_mr, mw: sm_mw, wb: sm_wb, b: sm_b,
          s: sm_s, dest: sm_dest, src1: sm_src1, src2: sm_src2,
          status: sm_status, valid: sm_valid};
    return f;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fields"},  256'(outputs_now()),       256'(exp_f));
    check({tag, ".sfields"}, 256'(small_outputs_now()), 256'(exp_f));
    check({tag, ".bubbles"}, 256'(bubble_count),        256'(sat(n_bubbles, 16)));
    check({tag, ".stalls"},  256'(stall_count),         256'(sat(n_stalls, 16)));
    check({tag, ".sbubbles"}, 256'(sm_bubble_count),    256'(sat(n_bubbles, 4)));
    check({tag, ".sstalls"}, 256'(sm_stall_count),      256'(sat(n_stalls, 4)));
  endtask

  task automatic model_reset();
    exp_f     = '0;
    n_bubbles = 0;
    n_stalls  = 0;
  endtask

  // One clock edge: advance the model from the spec's priority rules, then check.
  task automatic step(input string tag);
    fields_t cur;
    @(posedge clk);
    cur = inputs_now();
    if (mem_stall) begin
      n_stalls++;
    end else if (flush || hazard) begin
      exp_f = '0;
      n_bubbles++;
    end else begin
      exp_f = cur;
    end
    #1;
    check_all(tag);
  endtask

  task automatic zero_inputs();
    {mem_stall, flush, hazard} = '0;
    {pc_in, val_rn_in, val_rm_in} = '0;
    shift_operand_in = '0; signed_imm_24_in = '0;
    {imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in} = '0;
    {exe_cmd_in, dest_in, src1_in, src2_in, status_in} = '0;
  endtask

  task automatic rand_data();
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
    {imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in} = 6'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom);
    src1_in = 4'($urandom); src2_in = 4'($urandom); status_in = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal load
    pc_in = 32'h10; val_rn_in = 32'hDEADBEEF; dest_in = 4'd3; src1_in = 4'd1; wb_en_in = 1'b1;
    step("load");
    check("load.dest", 256'(dest_out), 256'(3));
    check("load.valid", 256'(valid_out), 256'(1));

    // Stall beats flush; inputs changing must not leak through
    mem_stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step("stall");
    end
    check("stall.pc", 256'(pc_out), 256'(32'h10));
    check("stall.cnt", 256'(stall_count), 256'(3));
    check("stall.bub", 256'(bubble_count), 256'(0));

    // Flush, hazard, then both
    mem_stall = 1'b0; rand_data(); wb_en_in = 1'b1; dest_in = 4'd9;
    flush = 1'b1; hazard = 1'b0; step("flush");
    flush = 1'b0; hazard = 1'b1; step("hazard");
    flush = 1'b1; hazard = 1'b1; step("both");
    check("bub.cnt", 256'(bubble_count), 256'(3));
    check("bub.wb", 256'(wb_en_out), 256'(0));

    // Recovery after a bubble
    flush = 1'b0; hazard = 1'b1; step("rec.bubble");
    hazard = 1'b0; rand_data(); dest_in = 4'd5; step("rec.load");
    check("rec.dest", 256'(dest_out), 256'(5));
    check("rec.valid", 256'(valid_out), 256'(1));

    // Saturation of the 4-bit stall counter
    mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step("sat");
    end
    check("sat.small", 256'(sm_stall_count), 256'(15));

    // Asynchronous reset mid-cycle with all inputs driven high
    mem_stall = 1'b0; rand_data(); step("pre_rst");
    {mem_stall, flush, hazard} = '1;
    {pc_in, val_rn_in, val_rm_in} = '1;
    shift_operand_in = '1; signed_imm_24_in = '1;
    {imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in} = '1;
    {exe_cmd_in, dest_in, src1_in, src2_in, status_in} = '1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("post_rst");

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      rand_data();
      mem_stall = ($urandom_range(0, 99) < 20);
      flush     = ($urandom_range(0, 99) < 15);
      hazard    = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        #1 rst = 1'b0;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_id_exe_stage_reg
`default_nettype wire

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode stage (register file read, control unit) and the execute stage.
- Captures operands, control and source/destination register addresses.
- Its src1/src2/dest outputs feed the forwarding and hazard logic; its data and control outputs feed the execute ALU and operand muxes.
- Handles memory-stall hold, branch flush and hazard bubble insertion, and keeps saturating bubble and stall event counters.

Parameters:
- DATA_W, 32, width of PC and register operand values.
- REG_ADDR_W, 4, register file address width.
- CNT_W, 16, width of the bubble and stall event counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_stall  in  1  memory not ready; hold all state.
- flush  in  1  branch taken in execute; insert bubble.
- hazard  in  1  load-use hazard from hazard unit; insert bubble.
- pc_in  in  DATA_W  decode-stage PC+4.
- val_rn_in, val_rm_in  in  DATA_W each  register file read data.
- shift_operand_in  in  12  instruction bits [11:0].
- signed_imm_24_in  in  24  branch offset.
- imm_in  in  1  immediate operand flag.
- exe_cmd_in  in  4  ALU command.
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  control bits.
- dest_in, src1_in, src2_in  in  REG_ADDR_W each  destination and source register addresses.
- status_in  in  4  NZCV from the status register (C is used by ADC/SBC).
- *_out  out  (same widths)  registered copy of every *_in above.
- valid_out  out  1  execute stage holds a real instruction.
- bubble_count  out  CNT_W  number of bubbles inserted (flush or hazard).
- stall_count  out  CNT_W  number of cycles held by mem_stall.

Behaviour:
- Reset (async, rst=1): every output cleared to 0, including valid_out and both counters.
- Per rising edge, one action applies, in priority order:
  1. mem_stall=1: hold every output unchanged. stall_count += 1 (saturating). flush and hazard are ignored this cycle, because the upstream/downstream stages are frozen too.
  2. flush=1: bubble. wb_en, mem_r_en, mem_w_en, b, s and valid_out are cleared; data fields, dest/src and exe_cmd are cleared to 0. bubble_count += 1.
  3. hazard=1: identical bubble; bubble_count += 1. flush and hazard together count once.
  4. Otherwise: load all *_in into *_out; valid_out=1.
- Latency: one cycle from *_in to *_out.
- Bubble contract: src1_out=src2_out=dest_out=0 with wb_en_out=0, so no forwarding or writeback can result.
- Counters: saturate at all-ones and never wrap; they are read-only with no clear other than rst.
- rst asserted mid-stall or mid-bubble: immediate clear. First post-reset edge follows the normal priority.
- No combinational path from any input to any output.

Decomposition:
- Shared constants include: EXE_CMD_LEN (4), SHIFT_OPERAND_LEN (12), SIGNED_IMM_LEN (24), STATUS_LEN (4) and REGISTER_FILE_ADDRESS_LEN, alongside the existing forwarding select codes.
- One sub-module: sat_counter (CNT_W parameter, inc input, async reset). Instantiate it twice, once for bubble_count and once for stall_count.
- Keep the field register inline.

Test Plan:
- Reset: drive all inputs to 1 and pulse rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; valid_out=0.
- Normal load: pc_in=0x10, val_rn_in=0xDEADBEEF, dest_in=3, src1_in=1, wb_en_in=1 -> next edge the outputs equal those values and valid_out=1.
- Stall priority: load as above, then mem_stall=1 with flush=1 for 3 cycles while the inputs change -> outputs frozen, stall_count=3, bubble_count=0.
- Flush and hazard: flush=1 for one edge, then hazard=1 for one edge, then both together for one edge -> wb_en_out=0, dest_out=0, valid_out=0 after each; bubble_count=3.
- Saturation: CNT_W=4, hold mem_stall=1 for 20 cycles -> stall_count stops at 15.
- Recovery: hazard=1 for one edge, then normal inputs with dest_in=5 -> the edge after the bubble gives dest_out=5 and valid_out=1.
